branch_predictor_table: RTL and testbench
=========================================

# branch_predictor_table

Parametrised dynamic branch predictor for the fetch/decode stage. It keeps a PC-indexed table of saturating counters, optionally hashed with a global history register (gshare mode), and returns a taken/not-taken decision each cycle. Static branch encodings bypass the table. Resolved branches from execute train the table one cycle later and are counted for performance monitoring.

## Interface
Parameters:
- ENTRIES, 64: counter-table depth; power of two, ≥ 2; IDX_W = $clog2(ENTRIES)
- CTR_W, 2: saturating-counter width, 1..4
- GHR_W, 6: global-history length, 1..IDX_W
- GSHARE, 0: 0 = bimodal index, 1 = PC XOR history index
- PC_W, 32: program-counter width, ≥ IDX_W+2
- PERF_W, 16: mispredict-counter width

Ports:
- clk  in  1  clock
- rstn_h  in  1  active-low asynchronous reset
- branch_occr  in  2  00/01 = static not-taken/taken; 1x = dynamic, use table
- pred_pc  in  PC_W  PC of the branch being predicted
- branch_taken  out  1  prediction
- pred_idx  out  IDX_W  table index used; travels down the pipe with the branch
- upd_valid  in  1  a conditional branch resolved this cycle
- upd_idx  in  IDX_W  pred_idx that travelled with the resolving branch
- upd_taken  in  1  actual outcome
- upd_pred  in  1  prediction originally made for that branch
- ghr  out  GHR_W  current global history; bit 0 is the newest
- mispred_cnt  out  PERF_W  saturating mispredict count

## Operation
- Index: base = pred_pc[IDX_W+1:2]. When GSHARE=1, pred_idx = base ^ {zero-pad, ghr}. When GSHARE=0, pred_idx = base.
- Prediction:
  - branch_occr[1]=0: branch_taken = branch_occr[0].
  - branch_occr[1]=1: branch_taken = MSB of ctr[pred_idx].
- Update, when upd_valid=1:
  - upd_taken=1: ctr[upd_idx] increments and saturates at 2^CTR_W−1.
  - upd_taken=0: ctr[upd_idx] decrements and saturates at 0.
  - ghr <= {ghr[GHR_W−2:0], upd_taken}. For GHR_W=1, ghr <= upd_taken.
  - If upd_taken != upd_pred, mispred_cnt increments and holds at all-ones.
- upd_valid=0: table, ghr and mispred_cnt hold.
- Static branches never train. The execute stage asserts upd_valid only for dynamic (1x) branches.
- History is updated at resolution, not speculatively. There is no recovery port.

## Timing
- The prediction path is combinational: lookup to branch_taken and pred_idx in the same cycle.
- Updates take effect at the posedge where upd_valid=1. A lookup of the same index in that cycle returns the old counter, with no bypass. The new value is visible from the next cycle.
- GSHARE=1: pred_idx uses the ghr value registered before the current edge.
- Reset is asynchronous on assertion. Reset values:
  - every ctr = 2^(CTR_W−1)−1 (weakly not-taken; 0 when CTR_W=1)
  - ghr = 0
  - mispred_cnt = 0
- During reset, branch_taken = branch_occr[0] when branch_occr[1]=0, and 0 otherwise. pred_idx = base.
- Reset asserted mid-operation discards any in-flight update at that edge.
- One update per cycle. A single update is always well defined, so no conflict case exists.

## Structure
- bp_pkg holds:
  - occr_e enum: OCCR_NT=2'b00, OCCR_T=2'b01, OCCR_DYN=2'b10/11 (decode on bit 1)
  - function ctr_init(CTR_W)
  - function sat_inc/sat_dec on a CTR_W vector
- One sub-module, bp_sat_ctr:
  - a single CTR_W register with async reset, en and dir inputs, and MSB output
  - instantiated ENTRIES times in a generate loop, each enabled by upd_valid && upd_idx==i
- Index hash, ghr and perf counter live in the top module.

## Test plan
- Reset, then sweep branch_occr 00/01 with any pc -> branch_taken 0/1. Dynamic lookup (10) anywhere -> 0, because every counter is 01.
- Bimodal, CTR_W=2, pc=0x40 (idx 16): two taken updates -> counter 11, predicts 1. Third taken -> still 11. One not-taken -> 10, still predicts 1. Second not-taken -> 01, predicts 0.
- Same-cycle lookup and update of idx 16 from counter 01, upd_taken=1 -> this cycle predicts 0, next cycle predicts 1.
- GSHARE=1, GHR_W=6: updates with outcomes 1,0,1 -> ghr=6'b000101. pc=0x40 -> pred_idx = 16^5 = 21. Training idx 21 does not change idx 16.
- PERF_W=4: 20 updates with upd_taken != upd_pred -> mispred_cnt saturates at 15. Matching updates leave it unchanged.
- Assert rstn_h low mid-stream between edges -> counters, ghr and mispred_cnt reset immediately. An update presented at the next edge while reset is still low is ignored.

Source files
------------

// File: rtl/branch_predictor_table_pkg.sv
// Shared types and saturating-counter helpers for the branch predictor table.
package bp_pkg;

  localparam int unsigned CTR_MAX_W = 4;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  // Bit 1 set means dynamic (table lookup); 2'b11 also decodes as dynamic.
  typedef enum logic [1:0] {
    OCCR_NT  = 2'b00,
    OCCR_T   = 2'b01,
    OCCR_DYN = 2'b10
  } occr_e;

  function automatic ctr_t ctr_max(input int unsigned w);
    return ctr_t'((32'd1 << w) - 32'd1);
  endfunction

  // Weakly not-taken: 0 followed by all ones.
  function automatic ctr_t ctr_init(input int unsigned w);
    return ctr_t'((32'd1 << (w - 32'd1)) - 32'd1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t v, input int unsigned w);
    return (v >= ctr_max(w)) ? v : v + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t v);
    return (v == ctr_t'(0)) ? v : v - ctr_t'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// Lookup and resolution bus between fetch/execute and the predictor table.
interface branch_predictor_table_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned PERF_W = 16
);
  logic [1:0]        branch_occr;
  logic [PC_W-1:0]   pred_pc;
  logic              branch_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_pred;
  logic [GHR_W-1:0]  ghr;
  logic [PERF_W-1:0] mispred_cnt;

  modport master (
    output branch_occr, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    input  branch_taken, pred_idx, ghr, mispred_cnt
  );

  modport slave (
    input  branch_occr, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    output branch_taken, pred_idx, ghr, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_table_sat_ctr.sv
// One saturating prediction counter; exposes only its MSB as the taken bit.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic dir,
  output logic msb
);

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] nxt_c;

  always_comb begin
    nxt_c = ctr_q;
    if (dir) nxt_c = CTR_W'(sat_inc(ctr_t'(ctr_q), CTR_W));
    else     nxt_c = CTR_W'(sat_dec(ctr_t'(ctr_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ctr_q <= CTR_W'(ctr_init(CTR_W));
    else if (en) ctr_q <= nxt_c;
  end

  assign msb = ctr_q[CTR_W-1];

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed (optionally gshare-hashed) saturating-counter branch predictor
// with resolution-time history and a saturating mispredict counter.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 6,
  parameter int unsigned GSHARE  = 0,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PERF_W  = 16
) (
  input logic                    clk,
  input logic                    rstn_h,
  branch_predictor_table_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  occr_e             occr;
  logic [IDX_W-1:0]  base_idx;
  logic [IDX_W-1:0]  hist_idx;
  logic [IDX_W-1:0]  idx_c;
  logic [ENTRIES-1:0] ctr_msb;
  logic [GHR_W-1:0]  ghr_q;
  logic [PERF_W-1:0] mis_q;
  logic              mispredict;

  // Lookup: word-aligned PC bits, optionally folded with registered history.
  assign occr     = occr_e'(bus.branch_occr);
  assign base_idx = bus.pred_pc[IDX_W+1:2];
  assign hist_idx = IDX_W'(ghr_q);
  assign idx_c    = (GSHARE != 0) ? (base_idx ^ hist_idx) : base_idx;

  // Dynamic predictions are forced not-taken while reset is held.
  assign bus.branch_taken = occr[1] ? (rstn_h & ctr_msb[idx_c]) : (occr == OCCR_T);
  assign bus.pred_idx     = idx_c;
  assign bus.ghr          = ghr_q;
  assign bus.mispred_cnt  = mis_q;

  logic unused_pc;
  if (PC_W > IDX_W + 2) begin : g_pc_hi
    assign unused_pc = ^{bus.pred_pc[1:0], bus.pred_pc[PC_W-1:IDX_W+2]};
  end else begin : g_pc_lo
    assign unused_pc = ^bus.pred_pc[1:0];
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rstn_h),
      .en    (bus.upd_valid && (bus.upd_idx == IDX_W'(i))),
      .dir   (bus.upd_taken),
      .msb   (ctr_msb[i])
    );
  end

  assign mispredict = bus.upd_taken != bus.upd_pred;

  // History shifts in the resolved outcome; the truncating cast also covers GHR_W=1.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      ghr_q <= '0;
      mis_q <= '0;
    end else if (bus.upd_valid) begin
      ghr_q <= GHR_W'({ghr_q, bus.upd_taken});
      if (mispredict && (mis_q != '1)) mis_q <= mis_q + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench: a bimodal instance (PERF_W=4) and a gshare instance side by side.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  logic rstn_h = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(6), .PERF_W(4))  ifa ();
  branch_predictor_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(6), .PERF_W(16)) ifb ();

  branch_predictor_table #(.ENTRIES(64), .CTR_W(2), .GHR_W(6), .GSHARE(0),
                           .PC_W(32), .PERF_W(4)) dut_a (
    .clk(clk), .rstn_h(rstn_h), .bus(ifa.slave));

  branch_predictor_table #(.ENTRIES(64), .CTR_W(2), .GHR_W(6), .GSHARE(1),
                           .PC_W(32), .PERF_W(16)) dut_b (
    .clk(clk), .rstn_h(rstn_h), .bus(ifb.slave));

  typedef enum int {A_TAKEN, A_IDX, A_GHR, A_MIS, B_TAKEN, B_IDX, B_GHR, B_MIS} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    int unsigned exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int unsigned actual(input sel_e s);
    case (s)
      A_TAKEN: return 32'(ifa.branch_taken);
      A_IDX:   return 32'(ifa.pred_idx);
      A_GHR:   return 32'(ifa.ghr);
      A_MIS:   return 32'(ifa.mispred_cnt);
      B_TAKEN: return 32'(ifb.branch_taken);
      B_IDX:   return 32'(ifb.pred_idx);
      B_GHR:   return 32'(ifb.ghr);
      default: return 32'(ifb.mispred_cnt);
    endcase
  endfunction

  // Monitor: outputs settle mid-cycle, so drain expectations on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      int unsigned act;
      e   = exp_q.pop_front();
      act = actual(e.sel);
      n_total++;
      if (act == e.exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
    end
  end

  task automatic expect_val(input string n, input sel_e s, input int unsigned v);
    exp_q.push_back('{n, s, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] occr, input logic [31:0] pc, input logic v,
                         input logic [5:0] idx, input logic t, input logic p);
    ifa.branch_occr = occr; ifa.pred_pc = pc; ifa.upd_valid = v;
    ifa.upd_idx = idx; ifa.upd_taken = t; ifa.upd_pred = p;
  endtask

  task automatic drive_b(input logic [1:0] occr, input logic [31:0] pc, input logic v,
                         input logic [5:0] idx, input logic t, input logic p);
    ifb.branch_occr = occr; ifb.pred_pc = pc; ifb.upd_valid = v;
    ifb.upd_idx = idx; ifb.upd_taken = t; ifb.upd_pred = p;
  endtask

  initial begin
    drive_a(2'b00, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    drive_b(2'b00, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);

    // Held in reset: static passthrough, dynamic forced low, index = base.
    step(); drive_a(2'b00, 32'h123, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("rst_static_nt", A_TAKEN, 0);
    expect_val("rst_idx_0x123", A_IDX, 8);
    step(); drive_a(2'b01, 32'h123, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("rst_static_t", A_TAKEN, 1);
    step(); drive_a(2'b10, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    drive_b(2'b10, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("rst_dyn", A_TAKEN, 0);
    expect_val("rst_idx_a", A_IDX, 16);
    expect_val("rst_idx_b", B_IDX, 16);
    @(negedge clk); #1 rstn_h = 1'b1;

    // c1..c3: three taken updates to idx 16; gshare sees outcomes 1,0,1.
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b1, 1'b1);
    drive_b(2'b10, 32'h40, 1'b1, 6'd0, 1'b1, 1'b1);
    expect_val("init_dyn_ctr01", A_TAKEN, 0);
    expect_val("init_ghr_a", A_GHR, 0);
    expect_val("init_mis_a", A_MIS, 0);
    expect_val("init_ghr_b", B_GHR, 0);
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b1, 1'b1);
    drive_b(2'b00, 32'h0, 1'b1, 6'd0, 1'b0, 1'b0);
    expect_val("ctr10_taken", A_TAKEN, 1);
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b1, 1'b1);
    drive_b(2'b00, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1);
    expect_val("ctr11_taken", A_TAKEN, 1);

    // c4: not-taken against taken prediction; gshare lookup hashed with ghr=5.
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b0, 1'b1);
    drive_b(2'b10, 32'h40, 1'b1, 6'd21, 1'b1, 1'b1);
    expect_val("ctr11_saturated", A_TAKEN, 1);
    expect_val("ghr_b_101", B_GHR, 5);
    expect_val("gshare_idx_21", B_IDX, 21);
    expect_val("gshare_ctr21_init", B_TAKEN, 0);
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b0, 1'b0);
    drive_b(2'b00, 32'h0, 1'b1, 6'd21, 1'b1, 1'b1);
    expect_val("ctr10_still_taken", A_TAKEN, 1);
    expect_val("mis_after_one", A_MIS, 1);

    // c6: counter back to 01 while the same index is trained taken this cycle.
    step(); drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b1, 1'b0);
    drive_b(2'b10, 32'h8, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("same_cycle_old_ctr", A_TAKEN, 0);
    expect_val("mis_matching_hold", A_MIS, 1);
    expect_val("ghr_b_0x17", B_GHR, 32'h17);
    expect_val("gshare_hit_21", B_IDX, 21);
    expect_val("gshare_ctr21_trained", B_TAKEN, 1);
    step(); drive_a(2'b10, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    drive_b(2'b10, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("next_cycle_new_ctr", A_TAKEN, 1);
    expect_val("mis_two", A_MIS, 2);
    expect_val("ghr_a_111001", A_GHR, 32'h39);
    expect_val("gshare_hit_16", B_IDX, 16);
    expect_val("gshare_ctr16_untouched", B_TAKEN, 0);
    expect_val("mis_b_zero", B_MIS, 0);
    step(); drive_a(2'b10, 32'h44, 1'b0, 6'd0, 1'b0, 1'b0);
    drive_b(2'b00, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("neighbour_idx", A_IDX, 17);
    expect_val("neighbour_ctr", A_TAKEN, 0);

    // Twenty mispredicts saturate the 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      step(); drive_a(2'b01, 32'h0, 1'b1, 6'd0, 1'b1, 1'b0);
      if (i == 1) expect_val("mis_three", A_MIS, 3);
    end
    step(); drive_a(2'b00, 32'h0, 1'b1, 6'd0, 1'b1, 1'b1);
    expect_val("mis_saturated", A_MIS, 15);
    step(); drive_a(2'b10, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("mis_sat_hold", A_MIS, 15);
    expect_val("ghr_a_all_ones", A_GHR, 32'h3F);
    expect_val("ctr16_before_reset", A_TAKEN, 1);

    // Reset mid-cycle with a mispredicting update pending at the next edge.
    @(posedge clk); #3;
    rstn_h = 1'b0;
    drive_a(2'b10, 32'h40, 1'b1, 6'd16, 1'b1, 1'b0);
    expect_val("async_rst_mis", A_MIS, 0);
    expect_val("async_rst_ghr", A_GHR, 0);
    expect_val("async_rst_taken", A_TAKEN, 0);
    expect_val("async_rst_ghr_b", B_GHR, 0);
    step(); drive_a(2'b10, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    expect_val("rst_upd_ignored_mis", A_MIS, 0);
    expect_val("rst_upd_ignored_ghr", A_GHR, 0);
    #2 rstn_h = 1'b1;
    step();
    expect_val("post_rst_ctr16", A_TAKEN, 0);
    expect_val("post_rst_mis", A_MIS, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
